vote_window_sampler: RTL

//  Upstream feeder for the 5-input majority voter. Shifts a serial, validated sample

---
 rtl/lab3_pkg.sv | 12 +
 rtl/majority5.sv | 26 ++
 rtl/vote_window_sampler.sv | 92 +++++++++
 3 files changed

// File: rtl/lab3_pkg.sv
// Shared definitions for the sample window / voter slice: FSM encodings and window length.
package lab3_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  localparam int WIN_LEN = 5;

endpackage

// File: rtl/majority5.sv
// Combinational 5-input majority built as an 8:1 mux on the upper three bits,
// with each mux leg selecting a function of the lower two bits.
module majority5 (
  input  logic [4:0] bits,
  output logic       maj
);

  logic lo_and;
  logic lo_or;

  assign lo_and = bits[1] & bits[0];
  assign lo_or  = bits[1] | bits[0];

  // Ones among bits[4:2] decide how many of the low pair are still needed.
  always_comb begin
    maj = 1'b0;
    case (bits[4:2])
      3'b000:                 maj = 1'b0;
      3'b001, 3'b010, 3'b100: maj = lo_and;
      3'b011, 3'b101, 3'b110: maj = lo_or;
      3'b111:                 maj = 1'b1;
      default:                maj = 1'b0;
    endcase
  end

endmodule

// File: rtl/vote_window_sampler.sv
// Serial sample window feeding a 5-input majority vote, plus a hold-filtered
// (debounced) copy of the vote with a one-cycle change pulse.
module vote_window_sampler
  import lab3_pkg::*;
#(
  parameter int HOLD = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       sample_valid,
  input  logic       sample_in,
  output logic [4:0] window_out,
  output logic [2:0] fill_count,
  output logic       vote_valid,
  output logic       vote_out,
  output logic       stable_out,
  output logic       changed
);

  state_t     state;
  state_t     state_next;
  logic [4:0] window_next;
  logic [2:0] fill_next;
  logic       maj_now;
  logic       maj_next;
  logic [2:0] hold_cnt;
  logic [3:0] hold_inc;

  assign window_next = {window_out[3:0], sample_in};
  assign fill_next   = (fill_count == 3'(WIN_LEN)) ? fill_count : fill_count + 3'd1;
  assign hold_inc    = {1'b0, hold_cnt} + 4'd1;

  majority5 u_maj_now  (.bits(window_out),  .maj(maj_now));
  majority5 u_maj_next (.bits(window_next), .maj(maj_next));

  assign vote_valid = (state == ST_FULL);
  assign vote_out   = vote_valid & maj_now;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_next;
  end

  // Transitions land on the accepting edge itself, so FULL is known while filtering.
  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: begin
        if (sample_valid)
          state_next = (fill_next == 3'(WIN_LEN)) ? ST_FULL : ST_FILLING;
      end
      ST_FILLING: begin
        if (sample_valid && (fill_next == 3'(WIN_LEN)))
          state_next = ST_FULL;
      end
      ST_FULL:  state_next = ST_FULL;
      default:  state_next = ST_EMPTY;
    endcase
    if (reset || clear)
      state_next = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      window_out <= 5'd0;
      fill_count <= 3'd0;
      stable_out <= 1'b0;
      hold_cnt   <= 3'd0;
      changed    <= 1'b0;
    end else if (sample_valid) begin
      window_out <= window_next;
      fill_count <= fill_next;
      changed    <= 1'b0;
      // The filter judges the window as it will be after this sample.
      if (state_next == ST_FULL) begin
        if (maj_next == stable_out) begin
          hold_cnt <= 3'd0;
        end else if (hold_inc == 4'(HOLD)) begin
          stable_out <= maj_next;
          hold_cnt   <= 3'd0;
          changed    <= 1'b1;
        end else begin
          hold_cnt <= hold_inc[2:0];
        end
      end
    end else begin
      changed <= 1'b0;
    end
  end

endmodule
